// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// irq_ctrl : latches, masks and prioritises peripheral interrupts, then
//            redirects fetch via req/ack and restores the EPC on mret.
// Optional:  IRQ_LEVEL_EN selects level-sensitive sources instead of edges.
// Revision:  1.0
// ============================================================================
module irq_ctrl #(
  parameter int          NUM_SRC  = 4,
  parameter logic [31:0] VEC_BASE = 32'h0000_0100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               reg_wr_en,
  input  logic               reg_rd_en,
  input  logic [1:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata,
  input  logic [31:0]        pc_in,
  output logic               irq_req,
  output logic [31:0]        irq_vector,
  input  logic               irq_ack,
  input  logic               mret,
  output logic               ret_valid,
  output logic [31:0]        ret_pc,
  output logic               in_isr
);

  localparam int         ID_W            = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [1:0] c_ADDR_PENDING  = 2'd0;
  localparam logic [1:0] c_ADDR_ENABLE   = 2'd1;
  localparam logic [1:0] c_ADDR_CTRL     = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ISR  = 2'd2
  } state_t;

  state_t             r_state;
  logic [NUM_SRC-1:0] r_sync;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_enable;
  logic               r_gie;
  logic [31:0]        r_epc;
  logic [ID_W-1:0]    r_id;

  logic [NUM_SRC-1:0] w_eligible;
  logic               w_any;
  logic [ID_W-1:0]    w_id;
  logic [31:0]        w_vec;
  logic               w_unused_bits;

  assign w_unused_bits = ^{reg_wdata[31:NUM_SRC], r_id};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= irq_src;
    end
  end

`ifdef IRQ_LEVEL_EN
  // Level mode: pending simply mirrors the synchronised lines.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= r_sync;
    end
  end
`else
  logic [NUM_SRC-1:0] r_prev;
  logic               r_armed;
  logic [NUM_SRC-1:0] w_edge;
  logic [NUM_SRC-1:0] w_w1c;
  logic [NUM_SRC-1:0] w_ack_clr;
  logic               w_ack_take;

  // First cycle after reset loads prev from the raw line so a source held
  // high through reset is not seen as a fresh edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_prev  <= '0;
      r_armed <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      r_prev  <= r_armed ? r_sync : irq_src;
    end
  end

  assign w_edge     = r_sync & ~r_prev;
  assign w_w1c      = (reg_wr_en && (reg_addr == c_ADDR_PENDING)) ?
                      reg_wdata[NUM_SRC-1:0] : '0;
  assign w_ack_take = (r_state == S_REQ) && irq_ack;

  always_comb begin
    w_ack_clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_ack_take && (r_id == ID_W'(i))) begin
        w_ack_clr[i] = 1'b1;
      end
    end
  end

  // A new edge wins over any clear landing on the same bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~(w_w1c | w_ack_clr)) | w_edge;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_enable <= '0;
      r_gie    <= 1'b0;
    end else if (reg_wr_en) begin
      case (reg_addr)
        c_ADDR_ENABLE: r_enable <= reg_wdata[NUM_SRC-1:0];
        c_ADDR_CTRL:   r_gie    <= reg_wdata[0];
        default:       ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      reg_rdata <= '0;
    end else if (reg_rd_en) begin
      case (reg_addr)
        c_ADDR_PENDING: reg_rdata <= {{(32-NUM_SRC){1'b0}}, r_pending};
        c_ADDR_ENABLE:  reg_rdata <= {{(32-NUM_SRC){1'b0}}, r_enable};
        c_ADDR_CTRL:    reg_rdata <= {31'b0, r_gie};
        default:        reg_rdata <= r_epc;
      endcase
    end
  end

  assign w_eligible = r_pending & r_enable & {NUM_SRC{r_gie}};
  assign w_any      = |w_eligible;

  // Scan from the top so the lowest eligible index is the last assignment.
  always_comb begin
    w_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_eligible[i]) begin
        w_id = ID_W'(i);
      end
    end
  end

  assign w_vec = VEC_BASE + {{(30-ID_W){1'b0}}, w_id, 2'b00};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_id       <= '0;
      r_epc      <= '0;
      irq_req    <= 1'b0;
      irq_vector <= VEC_BASE;
      in_isr     <= 1'b0;
      ret_valid  <= 1'b0;
      ret_pc     <= '0;
    end else begin
      ret_valid <= 1'b0;
      ret_pc    <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_id       <= w_id;
            irq_req    <= 1'b1;
            irq_vector <= w_vec;
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          // Request is never retracted; only the ack moves us on.
          if (irq_ack) begin
            r_epc   <= pc_in;
            irq_req <= 1'b0;
            in_isr  <= 1'b1;
            r_state <= S_ISR;
          end
        end
        S_ISR: begin
          if (mret) begin
            ret_valid <= 1'b1;
            ret_pc    <= r_epc;
            in_isr    <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
// tb_irq_ctrl : scoreboard bench for irq_ctrl (edge-capture build).
// Revision:     1.0
// ============================================================================
module tb_irq_ctrl;

  localparam int          NUM_SRC  = 4;
  localparam logic [31:0] VEC_BASE = 32'h0000_0100;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [NUM_SRC-1:0] irq_src = '0;
  logic               reg_wr_en = 1'b0;
  logic               reg_rd_en = 1'b0;
  logic [1:0]         reg_addr = '0;
  logic [31:0]        reg_wdata = '0;
  logic [31:0]        reg_rdata;
  logic [31:0]        pc_in = '0;
  logic               irq_req;
  logic [31:0]        irq_vector;
  logic               irq_ack = 1'b0;
  logic               mret = 1'b0;
  logic               ret_valid;
  logic [31:0]        ret_pc;
  logic               in_isr;

  always #5 clk = ~clk;

  irq_ctrl #(.NUM_SRC(NUM_SRC), .VEC_BASE(VEC_BASE)) dut (
    .clk(clk), .reset(reset), .irq_src(irq_src),
    .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .pc_in(pc_in),
    .irq_req(irq_req), .irq_vector(irq_vector), .irq_ack(irq_ack),
    .mret(mret), .ret_valid(ret_valid), .ret_pc(ret_pc), .in_isr(in_isr)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_vec_q[$];
  logic [31:0] exp_ret_q[$];
  logic [31:0] exp_rd_q[$];
  string       rd_tag_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Output monitor: pops expectations as the DUT produces events.
  logic        prev_req = 1'b0;
  logic        prev_ret = 1'b0;
  logic        rd_d = 1'b0;
  logic [31:0] held_vec = '0;

  always @(posedge clk) rd_d <= reg_rd_en;

  always @(negedge clk) begin
    if (irq_req && !prev_req) begin
      if (exp_vec_q.size() == 0) check("unexp_req", {31'b0, irq_req}, 32'd0);
      else begin
        held_vec = exp_vec_q.pop_front();
        check("vector", irq_vector, held_vec);
      end
    end else if (irq_req && prev_req) begin
      check("vec_hold", irq_vector, held_vec);
    end
    if (ret_valid) begin
      check("ret_pulse_len", {31'b0, prev_ret}, 32'd0);
      if (exp_ret_q.size() == 0) check("unexp_ret", {31'b0, ret_valid}, 32'd0);
      else check("ret_pc", ret_pc, exp_ret_q.pop_front());
    end
    if (rd_d && exp_rd_q.size() > 0) begin
      check(rd_tag_q.pop_front(), reg_rdata, exp_rd_q.pop_front());
    end
    prev_req = irq_req;
    prev_ret = ret_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [1:0] addr, input logic [31:0] data);
    reg_wr_en = 1'b1; reg_addr = addr; reg_wdata = data;
    tick(1);
    reg_wr_en = 1'b0; reg_wdata = '0;
  endtask

  task automatic reg_read(input logic [1:0] addr, input logic [31:0] exp, input string tag);
    exp_rd_q.push_back(exp);
    rd_tag_q.push_back(tag);
    reg_rd_en = 1'b1; reg_addr = addr;
    tick(1);
    reg_rd_en = 1'b0;
  endtask

  task automatic pulse(input logic [NUM_SRC-1:0] mask);
    irq_src = irq_src | mask;
    tick(1);
    irq_src = irq_src & ~mask;
  endtask

  task automatic wait_req(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (irq_req) break;
      tick(1);
    end
    check("req_seen", {31'b0, irq_req}, 32'd1);
  endtask

  task automatic do_ack();
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    check("ack_req_drop", {31'b0, irq_req}, 32'd0);
    check("ack_in_isr", {31'b0, in_isr}, 32'd1);
  endtask

  task automatic do_mret(input logic [31:0] exp_pc);
    exp_ret_q.push_back(exp_pc);
    mret = 1'b1;
    tick(1);
    mret = 1'b0;
    check("mret_isr_off", {31'b0, in_isr}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1);
  end

  initial begin
    // Reset state
    reset = 1'b0;
    tick(2);
    check("rst_req", {31'b0, irq_req}, 32'd0);
    check("rst_isr", {31'b0, in_isr}, 32'd0);
    check("rst_ret", {31'b0, ret_valid}, 32'd0);
    check("rst_vec", irq_vector, VEC_BASE);
    check("rst_retpc", ret_pc, 32'd0);
    check("rst_rdata", reg_rdata, 32'd0);
    reset = 1'b1;
    tick(1);
    for (int a = 0; a < 4; a++) reg_read(2'(a), 32'd0, "rst_reg");

    // Basic timer interrupt with latency
    reg_write(2'd1, 32'h1);
    reg_write(2'd2, 32'h1);
    pc_in = 32'h40;
    exp_vec_q.push_back(32'h100);
    irq_src[0] = 1'b1;
    tick(1);
    irq_src[0] = 1'b0;
    check("lat_c1", {31'b0, irq_req}, 32'd0);
    tick(1);
    check("lat_c2", {31'b0, irq_req}, 32'd0);
    tick(1);
    check("lat_c3", {31'b0, irq_req}, 32'd1);
    tick(1);
    do_ack();
    reg_read(2'd3, 32'h40, "epc_basic");
    reg_read(2'd0, 32'h0, "pend_after_ack");
    do_mret(32'h40);
    tick(2);

    // Priority: sources 1 and 2 together
    reg_write(2'd1, 32'hF);
    pc_in = 32'h200;
    exp_vec_q.push_back(32'h104);
    exp_vec_q.push_back(32'h108);
    pulse(4'b0110);
    wait_req(10);
    do_ack();
    do_mret(32'h200);
    pc_in = 32'h300;
    wait_req(10);
    do_ack();
    do_mret(32'h300);
    tick(2);

    // Masking by GIE
    reg_write(2'd2, 32'h0);
    pulse(4'b0001);
    tick(5);
    check("mask_noreq", {31'b0, irq_req}, 32'd0);
    reg_read(2'd0, 32'h1, "mask_pend");
    exp_vec_q.push_back(32'h100);
    reg_write(2'd2, 32'h1);
    check("gie_lat1", {31'b0, irq_req}, 32'd0);
    tick(1);
    check("gie_lat2", {31'b0, irq_req}, 32'd1);
    pc_in = 32'h44;
    do_ack();
    do_mret(32'h44);
    tick(2);

    // Hold while software disables everything during REQ
    exp_vec_q.push_back(32'h100);
    pulse(4'b0001);
    wait_req(10);
    reg_write(2'd1, 32'h0);
    reg_write(2'd2, 32'h0);
    reg_write(2'd0, 32'h1);
    tick(2);
    check("hold_req", {31'b0, irq_req}, 32'd1);
    check("hold_vec", irq_vector, 32'h100);
    pc_in = 32'h48;
    do_ack();
    do_mret(32'h48);

    // W1C colliding with a new edge on source 3
    irq_src[3] = 1'b1;
    tick(1);
    irq_src[3] = 1'b0;
    reg_write(2'd0, 32'h8);
    reg_read(2'd0, 32'h8, "w1c_set_wins");
    reg_write(2'd0, 32'h8);
    reg_read(2'd0, 32'h0, "w1c_clear");

    // No nesting; pending request follows mret
    reg_write(2'd1, 32'hF);
    reg_write(2'd2, 32'h1);
    exp_vec_q.push_back(32'h100);
    pc_in = 32'h500;
    pulse(4'b0001);
    wait_req(10);
    do_ack();
    pulse(4'b0010);
    tick(5);
    check("nest_noreq", {31'b0, irq_req}, 32'd0);
    reg_read(2'd0, 32'h2, "nest_pend");
    exp_vec_q.push_back(32'h104);
    do_mret(32'h500);
    check("b2b_c1", {31'b0, irq_req}, 32'd0);
    tick(1);
    check("b2b_c2", {31'b0, irq_req}, 32'd1);
    pc_in = 32'h600;
    do_ack();
    do_mret(32'h600);
    tick(2);

    // Stray mret / ack in IDLE
    mret = 1'b1;
    tick(1);
    mret = 1'b0;
    check("stray_mret", {31'b0, ret_valid}, 32'd0);
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    check("stray_ack", {31'b0, in_isr}, 32'd0);

    // Reset mid-REQ with source 2 held high through reset
    exp_vec_q.push_back(32'h100);
    pulse(4'b0001);
    wait_req(10);
    irq_src[2] = 1'b1;
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    check("rreq_req", {31'b0, irq_req}, 32'd0);
    check("rreq_isr", {31'b0, in_isr}, 32'd0);
    check("rreq_vec", irq_vector, VEC_BASE);
    for (int a = 0; a < 4; a++) reg_read(2'(a), 32'd0, "rreq_reg");
    tick(4);
    reg_read(2'd0, 32'd0, "no_edge_after_rst");
    irq_src = '0;

    tick(3);
    check("vec_q_empty", 32'(exp_vec_q.size()), 32'd0);
    check("ret_q_empty", 32'(exp_ret_q.size()), 32'd0);
    check("rd_q_empty", 32'(exp_rd_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt controller: the receiving end of the peripheral interrupt lines, such as the timer's `timer_interrupt`.
- Latches interrupt events, masks and prioritises them, and requests a PC redirect from the instruction fetch unit via a req/ack handshake.
- Saves the return PC; on `mret` from the control unit, hands the return PC back to fetch.
- Software configures it through a small memory-mapped register window driven by the datapath.

Parameters:
- NUM_SRC, 4, number of interrupt sources; 1..8; source 0 is the timer.
- VEC_BASE, 32'h0000_0100, vector base; handler address = VEC_BASE + 4*id.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- irq_src  in  NUM_SRC  raw interrupt lines from peripherals
- reg_wr_en  in  1  register write strobe
- reg_rd_en  in  1  register read strobe
- reg_addr  in  2  register select
- reg_wdata  in  32  write data
- reg_rdata  out  32  read data, registered
- pc_in  in  32  PC of the instruction to resume (fetch `current_pc`)
- irq_req  out  1  redirect request to fetch
- irq_vector  out  32  handler address, valid while irq_req=1
- irq_ack  in  1  fetch accepted redirect
- mret  in  1  return-from-interrupt pulse from the control unit
- ret_valid  out  1  one-cycle pulse: fetch loads ret_pc
- ret_pc  out  32  saved EPC
- in_isr  out  1  handler active

Behaviour:
- Register map:
  - 0 PENDING: read = pending bits; a write of 1 clears that bit (W1C).
  - 1 ENABLE: per-source mask, bits [NUM_SRC-1:0].
  - 2 CTRL: bit0 is GIE.
  - 3 EPC: read-only.
  - Unused bits read 0.
- Reads: reg_rdata updates the cycle after reg_rd_en and holds its value otherwise.
- Edge capture:
  - irq_src is registered once; a rising edge (prev=0, now=1) sets PENDING[i].
  - If a set and a W1C clear hit the same bit in the same cycle, set wins.
- Eligible sources = PENDING & ENABLE & {GIE}.
- Priority: the lowest eligible index wins, fixed.
- FSM states IDLE, REQ, ISR:
  - IDLE: if any source is eligible, latch id; go to REQ next cycle with irq_req=1 and irq_vector = VEC_BASE + (id<<2).
  - REQ: irq_req and irq_vector are held stable until irq_ack. They are not retracted even if software clears PENDING/ENABLE/GIE meanwhile.
  - On irq_ack in REQ:
    - EPC <= pc_in.
    - PENDING[id] cleared.
    - irq_req goes 0 next cycle.
    - State goes to ISR; in_isr=1.
    - irq_ack is taken in the same cycle it is seen.
  - ISR: no nesting; new edges still set PENDING but no request is raised.
  - On mret in ISR: ret_valid=1 and ret_pc=EPC for exactly one cycle; go to IDLE.
  - A pending eligible source may re-request the cycle after returning to IDLE, so back-to-back interrupts take a minimum of 2 cycles.
- Ignored inputs:
  - mret in IDLE or REQ: no effect.
  - irq_ack outside REQ: no effect.
- Latency: source edge to irq_req = 3 cycles (sync, pending, REQ).
- EPC write via reg_wr_en: no effect.
- Reset (reset=0 at a clk edge), including mid-REQ or mid-ISR:
  - State IDLE.
  - PENDING, ENABLE, CTRL, EPC and the sync registers = 0.
  - All outputs 0; irq_vector = VEC_BASE.
  - A source held high through reset does not create an edge after reset release.

Optional Feature:
- IRQ_LEVEL_EN defined:
  - Sources are level-sensitive: PENDING[i] equals the synchronised irq_src[i] every cycle.
  - W1C writes are ignored.
  - No clear on ack; the peripheral must drop its line.
  - The edge-detect register is not built.
- Undefined: edge-capture behaviour as above.

Test Plan:
- Basic timer interrupt:
  - Stimulus: ENABLE=1, CTRL=1; pulse irq_src[0] for 1 cycle; irq_ack 2 cycles after irq_req; pc_in=32'h0000_0040.
  - Required: irq_req rises 3 cycles after the edge with irq_vector=32'h100; EPC=32'h40; PENDING=0; in_isr=1.
  - Then mret: ret_valid for one cycle with ret_pc=32'h40.
- Priority:
  - Stimulus: ENABLE=4'b1111, GIE=1; edges on sources 2 and 1 in the same cycle.
  - Required: vector 32'h104 first; after mret, vector 32'h108.
- Masking:
  - Stimulus: GIE=0; edge on source 0.
  - Required: no irq_req; PENDING=1. Writing GIE=1 gives irq_req 2 cycles later.
- Hold and W1C:
  - Stimulus: while in REQ, write ENABLE=0.
  - Required: irq_req and irq_vector remain stable until ack.
  - Stimulus: W1C of bit 3 in the same cycle as a new edge on source 3.
  - Required: PENDING[3]=1.
- Nesting and stray inputs:
  - Stimulus: edge on source 1 during ISR.
  - Required: no irq_req until after mret, then the request follows.
  - Stimulus: mret in IDLE.
  - Required: ret_valid stays 0.
- Reset mid-REQ:
  - Stimulus: assert reset=0 for 1 cycle while irq_req=1.
  - Required: the cycle after, irq_req=0, in_isr=0, and all registers read 0.
